// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP multiplier arbiter.
//   state_t : arbiter FSM states
//   FP_W    : default operand/result width (IEEE-754 single)
//   clog2   : index width helper (minimum 1 bit)
package fp_arb_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req      : request vector
//   ptr      : highest-priority index for this round
//   onehot_c : one-hot winner (0 when no request)
//   idx_c    : winner index
//   valid_c  : at least one request present
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot_c,
  output logic [IW-1:0]    idx_c,
  output logic             valid_c
);

  // Scan from ptr upward with wrap; the first set bit wins.
  always_comb begin
    int unsigned c;
    onehot_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    c        = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      c = (32'(ptr) + i) % N_REQ;
      if (!valid_c && req[IW'(c)]) begin
        valid_c             = 1'b1;
        idx_c               = IW'(c);
        onehot_c[IW'(c)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier (start/done handshake,
// done high when idle) among N_REQ requesters.
// Optional watchdog enabled by macro FP_ARB_TIMEOUT_EN.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req, a_in, b_in     : requester levels and packed operands (slice i = requester i)
//   gnt                 : one-hot grant pulse, operands captured
//   resp_valid          : one-hot result pulse
//   resp_data, resp_err : result (held) and timeout flag
//   busy                : FSM not in IDLE
//   fp_start, fp_a, fp_b: multiplier launch pulse and operands
//   fp_done, fp_result  : multiplier status and result
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FP_W        = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*FP_W-1:0] a_in,
  input  logic [N_REQ*FP_W-1:0] b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]       resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  fp_start,
  output logic [FP_W-1:0]       fp_a,
  output logic [FP_W-1:0]       fp_b,
  input  logic                  fp_done,
  input  logic [FP_W-1:0]       fp_result
);

  localparam int unsigned IW = clog2(N_REQ);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [N_REQ-1:0] sel_oh;

  logic [N_REQ-1:0] pick_oh_c;
  logic [IW-1:0]    pick_idx_c;
  logic             pick_valid_c;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req      (req),
    .ptr      (ptr),
    .onehot_c (pick_oh_c),
    .idx_c    (pick_idx_c),
    .valid_c  (pick_valid_c)
  );

`ifdef FP_ARB_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  logic          tcnt_hit_c;

  assign tcnt_hit_c = (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign resp_err = 1'b0;
`endif

  // Arbiter FSM; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      idx        <= '0;
      sel_oh     <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
      fp_start   <= 1'b0;
      fp_a       <= '0;
      fp_b       <= '0;
`ifdef FP_ARB_TIMEOUT_EN
      tcnt       <= '0;
      resp_err   <= 1'b0;
`endif
    end else begin
      gnt        <= '0;
      fp_start   <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          // Only arbitrate while the multiplier reports idle.
          if (pick_valid_c && fp_done) begin
            idx      <= pick_idx_c;
            sel_oh   <= pick_oh_c;
            gnt      <= pick_oh_c;
            fp_start <= 1'b1;
            busy     <= 1'b1;
            fp_a     <= FP_W'(a_in >> (32'(pick_idx_c) * FP_W));
            fp_b     <= FP_W'(b_in >> (32'(pick_idx_c) * FP_W));
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef FP_ARB_TIMEOUT_EN
          tcnt  <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
`ifdef FP_ARB_TIMEOUT_EN
          tcnt <= tcnt + 1'b1;
          if (!fp_done) begin
            state <= WAIT_DONE;
          end else if (tcnt_hit_c) begin
            resp_valid <= sel_oh;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end
`else
          if (!fp_done) state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
`ifdef FP_ARB_TIMEOUT_EN
          tcnt <= tcnt + 1'b1;
          if (fp_done) begin
            resp_valid <= sel_oh;
            resp_data  <= fp_result;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if (tcnt_hit_c) begin
            resp_valid <= sel_oh;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end
`else
          if (fp_done) begin
            resp_valid <= sel_oh;
            resp_data  <= fp_result;
            state      <= RESP;
          end
`endif
        end
        RESP: begin
          // Next round starts just past the requester that was served.
          ptr   <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter with a behavioural
// start/done multiplier model (fixed latency, programmable result).
module tb_fp_mul_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 16;
  localparam int          BOUND = 60;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic           fp_start;
  logic [W-1:0]   fp_a;
  logic [W-1:0]   fp_b;
  logic           fp_done;
  logic [W-1:0]   fp_result;

  int checks = 0;
  int errors = 0;

  // Multiplier model
  logic         mdl_done = 1'b1;
  int           mdl_cnt  = 0;
  logic [W-1:0] mdl_res  = '0;
  logic [W-1:0] next_result = '0;
  logic         hold_low = 1'b0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(
    .N_REQ       (N),
    .FP_W        (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .fp_start   (fp_start),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_done    (fp_done),
    .fp_result  (fp_result)
  );

  always @(posedge clk) begin
    if (fp_start) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= 5;
    end else if (!mdl_done) begin
      if (mdl_cnt <= 1) begin
        mdl_done <= 1'b1;
        mdl_res  <= next_result;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  assign fp_done   = mdl_done && !hold_low;
  assign fp_result = mdl_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == '0 && n < BOUND) begin
      tick();
      n++;
    end
    chk("gnt_arrives", 64'(gnt != '0), 64'd1);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid == '0 && n < BOUND) begin
      tick();
      n++;
    end
    chk("resp_arrives", 64'(resp_valid != '0), 64'd1);
  endtask

  initial begin
    int n;
    int order [5];
    logic [N-1:0] seen;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_pulses", 64'({gnt, resp_valid, busy, fp_start, resp_err}), 64'd0);
    chk("rst_fp_a", 64'(fp_a), 64'd0);
    chk("rst_fp_b", 64'(fp_b), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single multiply 2.0 * 3.0 = 6.0
    a_in[0*W +: W] = 32'h4000_0000;
    b_in[0*W +: W] = 32'h4040_0000;
    next_result    = 32'h40C0_0000;
    req = 4'b0001;
    tick();
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_start", 64'(fp_start), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_fp_a", 64'(fp_a), 64'h4000_0000);
    chk("t1_fp_b", 64'(fp_b), 64'h4040_0000);
    req = '0;
    tick();
    chk("t1_gnt_pulse", 64'({gnt, fp_start}), 64'd0);
    wait_resp(n);
    chk("t1_resp_lat", 64'(n + 1), 64'd7);
    chk("t1_resp_valid", 64'(resp_valid), 64'h1);
    chk("t1_resp_data", 64'(resp_data), 64'h40C0_0000);
    chk("t1_resp_err", 64'(resp_err), 64'd0);
    tick();
    chk("t1_resp_pulse", 64'(resp_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_data_held", 64'(resp_data), 64'h40C0_0000);

    // 2: all requesting from reset, order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_in[i*W +: W] = 32'h3F80_0000 + 32'(i);
      b_in[i*W +: W] = 32'h4080_0000 + 32'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      next_result = 32'h4100_0000 + 32'(k);
      wait_gnt(n);
      chk("t2_gnt", 64'(gnt), 64'(4'b0001 << order[k]));
      chk("t2_fp_a", 64'(fp_a), 64'(32'h3F80_0000 + 32'(order[k])));
      wait_resp(n);
      chk("t2_resp_valid", 64'(resp_valid), 64'(4'b0001 << order[k]));
      chk("t2_resp_data", 64'(resp_data), 64'(32'h4100_0000 + 32'(k)));
    end
    req = '0;
    tick();
    tick();

    // 3: after grant 2, req 1011 -> grants 3 then 0
    do_reset();
    req = 4'b0100;
    wait_gnt(n);
    chk("t3_gnt2", 64'(gnt), 64'h4);
    req = 4'b1011;
    wait_resp(n);
    wait_gnt(n);
    chk("t3_gnt3", 64'(gnt), 64'h8);
    wait_resp(n);
    wait_gnt(n);
    chk("t3_gnt0", 64'(gnt), 64'h1);
    req = '0;
    wait_resp(n);
    chk("t3_resp0", 64'(resp_valid), 64'h1);
    tick();

    // 4: multiplier reports not-done while idle
    do_reset();
    hold_low    = 1'b1;
    next_result = 32'h3E00_0000;
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_gnt", 64'({gnt, fp_start, busy}), 64'd0);
    end
    hold_low = 1'b0;
    tick();
    chk("t4_gnt", 64'(gnt), 64'h1);
    chk("t4_start", 64'(fp_start), 64'd1);
    req = '0;
    wait_resp(n);
    chk("t4_resp_data", 64'(resp_data), 64'h3E00_0000);
    tick();

    // 5: async reset in WAIT_DONE aborts with no response
    req = 4'b0100;
    wait_gnt(n);
    chk("t5_gnt", 64'(gnt), 64'h4);
    req = '0;
    tick();
    tick();
    tick();
    chk("t5_in_wait", 64'({busy, resp_valid}), 64'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pulses", 64'({gnt, resp_valid, busy, fp_start, resp_err}), 64'd0);
    chk("t5_rst_fp_a", 64'(fp_a), 64'd0);
    chk("t5_rst_data", 64'(resp_data), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | resp_valid;
    end
    chk("t5_no_resp", 64'(seen), 64'd0);
    req = 4'b1111;
    wait_gnt(n);
    chk("t5_ptr0", 64'(gnt), 64'h1);
    req = '0;
    wait_resp(n);
    tick();

`ifdef FP_ARB_TIMEOUT_EN
    // 6: multiplier never finishes -> watchdog response
    req = 4'b0001;
    wait_gnt(n);
    chk("t6_gnt", 64'(gnt), 64'h1);
    req      = '0;
    hold_low = 1'b1;
    wait_resp(n);
    chk("t6_lat", 64'(n), 64'(TO + 1));
    chk("t6_resp_valid", 64'(resp_valid), 64'h1);
    chk("t6_err", 64'(resp_err), 64'd1);
    chk("t6_data", 64'(resp_data), 64'd0);
    hold_low = 1'b0;
    tick();
    chk("t6_idle", 64'({busy, resp_valid}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
